// File: rtl/fetch_pkg.sv
// Shared state encodings, fixed addresses and decode helpers for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RST_VEC = 2'd0,
    FETCH   = 2'd1,
    IMM     = 2'd2,
    INT_VEC = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VEC_ADDR = '0;
  localparam int unsigned INT_AREA_SIZE  = 32;
  localparam int unsigned INT_IDX_W      = $clog2(INT_AREA_SIZE);

  function automatic logic is_two_word(input logic [15:0] instr,
                                       input logic [15:0] mask,
                                       input logic [15:0] match);
    return (instr & mask) == match;
  endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Fetch state register with redirect > flush > interrupt > stall priority and edge-armed interrupt take.
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  logic   redirect,
  input  logic   int_req,
  input  logic   two_word,
  output state_t state,
  output logic   take_int,
  output logic   int_ack
);

  logic armed;

  always_comb begin
    take_int = (state == FETCH) && !redirect && !flush && !stall && int_req && armed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_VEC;
      armed   <= 1'b1;
      int_ack <= 1'b0;
    end else begin
      int_ack <= take_int;
      // Re-arm only once the level request has dropped.
      if (take_int)
        armed <= 1'b0;
      else if (!int_req)
        armed <= 1'b1;

      if (redirect)
        state <= FETCH;
      else if (take_int)
        state <= INT_VEC;
      else if (flush || !stall) begin
        case (state)
          RST_VEC: state <= FETCH;
          FETCH:   state <= two_word ? IMM : FETCH;
          IMM:     state <= FETCH;
          INT_VEC: state <= FETCH;
          default: state <= RST_VEC;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction-memory addressing and IF/ID assembly of one- and two-word instructions.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] IMM_MASK  = 16'hE000,
  parameter logic [15:0] IMM_MATCH = 16'hC000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  output logic        imem_wr,
  output logic        imem_cs,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        int_req,
  input  logic [4:0]  int_idx,
  output logic        int_ack,
  output logic [31:0] int_ret_pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_imm,
  output logic        if_has_imm,
  output logic [31:0] if_pc
);

  state_t      state;
  logic        take_int;
  logic        two_word;
  logic [31:0] pc;
  logic [31:0] hold_pc;
  logic [15:0] hold_op;
  logic [31:0] data_ext;
  logic [31:0] vec_addr;

  assign imem_rd  = 1'b1;
  assign imem_wr  = 1'b0;
  assign imem_cs  = 1'b1;
  assign data_ext = {16'h0000, imem_data};
  assign vec_addr = {{(32 - INT_IDX_W){1'b0}}, int_idx};
  assign two_word = is_two_word(imem_data, IMM_MASK, IMM_MATCH);

  always_comb begin
    case (state)
      RST_VEC: imem_addr = RESET_VEC_ADDR;
      INT_VEC: imem_addr = vec_addr;
      default: imem_addr = pc;
    endcase
  end

  fetch_fsm u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .flush    (flush),
    .redirect (redirect),
    .int_req  (int_req),
    .two_word (two_word),
    .state    (state),
    .take_int (take_int),
    .int_ack  (int_ack)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      hold_pc    <= '0;
      hold_op    <= '0;
      int_ret_pc <= '0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_imm     <= '0;
      if_has_imm <= 1'b0;
      if_pc      <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      case (state)
        RST_VEC, INT_VEC: pc <= data_ext;
        FETCH: begin
          pc <= pc + 32'd1;
          if (two_word) begin
            hold_op <= imem_data;
            hold_pc <= pc;
          end
        end
        // IMM: pc stays on the immediate word, which is refetched as an opcode.
        default: ;
      endcase
    end else if (take_int) begin
      int_ret_pc <= pc;
      if_valid   <= 1'b0;
    end else if (!stall) begin
      case (state)
        RST_VEC, INT_VEC: begin
          pc       <= data_ext;
          if_valid <= 1'b0;
        end
        FETCH: begin
          pc <= pc + 32'd1;
          if (two_word) begin
            hold_op  <= imem_data;
            hold_pc  <= pc;
            if_valid <= 1'b0;
          end else begin
            if_valid   <= 1'b1;
            if_instr   <= imem_data;
            if_imm     <= '0;
            if_has_imm <= 1'b0;
            if_pc      <= pc;
          end
        end
        IMM: begin
          pc         <= pc + 32'd1;
          if_valid   <= 1'b1;
          if_instr   <= hold_op;
          if_imm     <= imem_data;
          if_has_imm <= 1'b1;
          if_pc      <= hold_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven program plus directed corner sequences, IF/ID scoreboard.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has_imm;
    logic [31:0] pc;
  } ifid_t;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] op;
    logic [15:0] imm;
  } prog_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_rd, imem_wr, imem_cs;
  logic [15:0] imem_data;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        int_req;
  logic [4:0]  int_idx;
  logic        int_ack;
  logic [31:0] int_ret_pc;
  logic        if_valid;
  logic [15:0] if_instr, if_imm;
  logic        if_has_imm;
  logic [31:0] if_pc;

  logic [15:0] mem [0:1048575];
  ifid_t       exp_q[$];
  ifid_t       e;
  logic        upd = 1'b0;
  int          checks = 0;
  int          errors = 0;

  assign imem_data = mem[imem_addr[19:0]];

  always #5 clk = ~clk;

  fetch_unit #(.IMM_MASK(16'hE000), .IMM_MATCH(16'hC000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_wr(imem_wr),
    .imem_cs(imem_cs), .imem_data(imem_data), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .int_req(int_req), .int_idx(int_idx), .int_ack(int_ack),
    .int_ret_pc(int_ret_pc), .if_valid(if_valid), .if_instr(if_instr), .if_imm(if_imm),
    .if_has_imm(if_has_imm), .if_pc(if_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] m, input logic h, input logic [31:0] p);
    ifid_t r;
    r.instr = i; r.imm = m; r.has_imm = h; r.pc = p;
    exp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A new IF/ID value can only appear after an edge that was not a plain stall.
  always @(posedge clk) upd <= !stall || redirect || flush;

  always @(negedge clk) begin
    if (rst_n && if_valid && upd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ifid_unexpected: got instr 0x%0h pc 0x%0h, expected no instruction", if_instr, if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("ifid_word", {31'b0, if_instr, if_imm, if_has_imm}, {31'b0, e.instr, e.imm, e.has_imm});
        chk("ifid_pc", {32'b0, if_pc}, {32'b0, e.pc});
      end
    end
  end

  prog_t       prog [6];
  logic        expv[$];
  logic        two;
  logic [31:0] a;

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = '0; int_req = 1'b0; int_idx = '0;
    for (int unsigned i = 0; i < 1048576; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0020;

    prog[0] = '{32'h20, 16'h1234, 16'h0000};
    prog[1] = '{32'h21, 16'hC001, 16'hBEEF};
    prog[2] = '{32'h23, 16'h5555, 16'h0000};
    prog[3] = '{32'h24, 16'hDFFF, 16'h0102};
    prog[4] = '{32'h26, 16'hE000, 16'h0000};
    prog[5] = '{32'h27, 16'hA5A5, 16'h0000};

    expv.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      two = (prog[i].op & 16'hE000) == 16'hC000;
      a = prog[i].pc;
      mem[a[19:0]] = prog[i].op;
      if (two) begin
        a = prog[i].pc + 32'd1;
        mem[a[19:0]] = prog[i].imm;
        expv.push_back(1'b0);
      end
      expv.push_back(1'b1);
      push(prog[i].op, two ? prog[i].imm : 16'h0000, two, prog[i].pc);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", {32'b0, imem_addr}, 64'h0);
    chk("rst_valid", {63'b0, if_valid}, 64'h0);
    chk("rst_instr", {48'b0, if_instr}, 64'h0);
    chk("rst_strobes", {61'b0, imem_rd, imem_wr, imem_cs}, 64'h5);
    chk("rst_int_ack", {63'b0, int_ack}, 64'h0);
    rst_n = 1'b1;

    // Reset vector and table-driven program
    for (int k = 0; k < expv.size(); k++) begin
      step();
      chk("prog_valid", {63'b0, if_valid}, {63'b0, expv[k]});
      if (k == 0) chk("rstvec_target", {32'b0, imem_addr}, 64'h20);
    end
    stall = 1'b1;

    // Redirect while in IMM
    mem[20'h28] = 16'hC123; mem[20'h29] = 16'h7777; mem[20'h40] = 16'h4242;
    step();
    stall = 1'b0;
    step();
    chk("twoword_bubble", {63'b0, if_valid}, 64'h0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk("redir_valid", {63'b0, if_valid}, 64'h0);
    chk("redir_addr", {32'b0, imem_addr}, 64'h40);
    redirect = 1'b0;
    push(16'h4242, 16'h0000, 1'b0, 32'h40);
    step();
    chk("redir_if_pc", {32'b0, if_pc}, 64'h40);
    stall = 1'b1;

    // Three-cycle stall while holding an opcode
    mem[20'h41] = 16'hC0AA; mem[20'h42] = 16'h1111;
    step();
    stall = 1'b0;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ifid", {30'b0, if_valid, if_instr, if_imm, if_has_imm}, {30'b0, 1'b0, 16'h4242, 16'h0000, 1'b0});
      chk("stall_pc_addr", {if_pc, imem_addr}, {32'h40, 32'h42});
    end
    stall = 1'b0;
    push(16'hC0AA, 16'h1111, 1'b1, 32'h41);
    step();
    stall = 1'b1;

    // Redirect overrides stall, then interrupt vectoring
    mem[3] = 16'h0080; mem[20'h25] = 16'h3333; mem[20'h80] = 16'h9999;
    redirect = 1'b1; redirect_pc = 32'h25;
    step();
    chk("redir_over_stall", {32'b0, imem_addr}, 64'h25);
    redirect = 1'b0; stall = 1'b0; int_req = 1'b1; int_idx = 5'd3;
    step();
    chk("int_ack_pulse", {63'b0, int_ack}, 64'h1);
    chk("int_ret_pc", {32'b0, int_ret_pc}, 64'h25);
    chk("int_vec_addr", {32'b0, imem_addr}, 64'h3);
    chk("int_valid", {63'b0, if_valid}, 64'h0);
    push(16'h9999, 16'h0000, 1'b0, 32'h80);
    step();
    chk("int_ack_drop", {63'b0, int_ack}, 64'h0);
    chk("int_target", {32'b0, imem_addr}, 64'h80);
    step();
    push(16'h0000, 16'h0000, 1'b0, 32'h81);
    step();
    chk("int_not_retaken", {63'b0, int_ack}, 64'h0);
    stall = 1'b1; int_req = 1'b0;

    // Asynchronous reset in the middle of a two-word fetch
    mem[20'h82] = 16'hC777; mem[20'h83] = 16'h8888;
    mem[20'hFFFFF] = 16'h6666; mem[1] = 16'hC0F0; mem[2] = 16'hABCD;
    step();
    stall = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_if_pc", {32'b0, if_pc}, 64'h0);
    chk("async_addr", {32'b0, imem_addr}, 64'h0);
    chk("async_ret_pc", {32'b0, int_ret_pc}, 64'h0);
    chk("async_ifid", {30'b0, if_valid, if_instr, if_imm, if_has_imm}, 64'h0);

    // pc wrap via redirect to the last word address
    step();
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    push(16'h6666, 16'h0000, 1'b0, 32'hFFFF_FFFF);
    push(16'h0020, 16'h0000, 1'b0, 32'h0);
    step();
    chk("wrap_redir_addr", {32'b0, imem_addr}, 64'hFFFF_FFFF);
    redirect = 1'b0;
    step();
    chk("pc_wrap", {32'b0, imem_addr}, 64'h0);
    step();
    step();

    // Flush in IMM drops the partial instruction; flush in FETCH advances pc
    flush = 1'b1;
    step();
    chk("flush_imm_valid", {63'b0, if_valid}, 64'h0);
    chk("flush_imm_nop", {48'b0, if_instr}, 64'h0);
    chk("flush_imm_addr", {32'b0, imem_addr}, 64'h2);
    flush = 1'b0;
    push(16'hABCD, 16'h0000, 1'b0, 32'h2);
    step();
    flush = 1'b1;
    step();
    chk("flush_fetch_valid", {63'b0, if_valid}, 64'h0);
    chk("flush_fetch_nop", {48'b0, if_instr}, 64'h0);
    chk("flush_fetch_addr", {32'b0, imem_addr}, 64'h4);
    flush = 1'b0; stall = 1'b1;
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
